// File: rtl/lrrr_sequencer_if.sv
// rtl/lrrr_sequencer_if.sv - handshake bundle between game control, Lrrr sequencer and mover
// Purpose: groups the frame/game/hit inputs and the mover/draw/score outputs.
// Ports (signals):
//   startOfFrame, gameActive, lrrrHit          game control -> sequencer
//   idleN, toggleY                             sequencer -> mover
//   lrrrVisible, explodeOn                     sequencer -> drawing
//   lrrrShoot, hitBonus                        sequencer -> shooting / score
//   state[1:0]                                 sequencer state (0 IDLE, 1 WAIT, 2 FLY, 3 EXPLODE)
// Modports: master = game environment, slave = sequencer.
interface lrrr_sequencer_if;
   logic       startOfFrame;
   logic       gameActive;
   logic       lrrrHit;
   logic       idleN;
   logic       toggleY;
   logic       lrrrVisible;
   logic       explodeOn;
   logic       lrrrShoot;
   logic       hitBonus;
   logic [1:0] state;

   modport master (
      output startOfFrame, gameActive, lrrrHit,
      input  idleN, toggleY, lrrrVisible, explodeOn, lrrrShoot, hitBonus, state
   );

   modport slave (
      input  startOfFrame, gameActive, lrrrHit,
      output idleN, toggleY, lrrrVisible, explodeOn, lrrrShoot, hitBonus, state
   );
endinterface

// File: rtl/lrrr_sequencer.sv
// rtl/lrrr_sequencer.sv - Lrrr boss-ship life-cycle sequencer (spawn, fly, explode, respawn)
// Purpose: counts frames in each state and drives the mover's idleN/toggleY,
//   the draw enables, and the shot and bonus strobes. All outputs registered.
// Ports:
//   clk     in  system clock
//   resetN  in  asynchronous reset, active low
//   bus     lrrr_sequencer_if.slave (startOfFrame, gameActive, lrrrHit in;
//           idleN, toggleY, lrrrVisible, explodeOn, lrrrShoot, hitBonus, state out)
module lrrr_sequencer #(
   parameter int SPAWN_DELAY    = 90,
   parameter int FLY_FRAMES     = 300,
   parameter int TOGGLE_PERIOD  = 45,
   parameter int SHOT_PERIOD    = 60,
   parameter int EXPLODE_FRAMES = 20
) (
   input logic              clk,
   input logic              resetN,
   lrrr_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_FLY     = 2'd2,
      S_EXPLODE = 2'd3
   } state_t;

   localparam logic [9:0] SPAWN_LIM   = 10'(SPAWN_DELAY);
   localparam logic [9:0] FLY_LIM     = 10'(FLY_FRAMES);
   localparam logic [9:0] TOGGLE_LIM  = 10'(TOGGLE_PERIOD);
   localparam logic [9:0] SHOT_LIM    = 10'(SHOT_PERIOD);
   localparam logic [9:0] EXPLODE_LIM = 10'(EXPLODE_FRAMES);

   state_t     cur_state, nxt_state;
   logic [9:0] frame_cnt, frame_nxt;
   logic [9:0] toggle_cnt, toggle_nxt;
   logic [9:0] shot_cnt, shot_nxt;
   logic [9:0] frame_inc, toggle_inc, shot_inc;
   logic       toggle_pulse, shot_pulse, bonus_pulse;

   assign frame_inc  = frame_cnt + 10'd1;
   assign toggle_inc = toggle_cnt + 10'd1;
   assign shot_inc   = shot_cnt + 10'd1;

   always_comb begin
      nxt_state    = cur_state;
      frame_nxt    = frame_cnt;
      toggle_nxt   = toggle_cnt;
      shot_nxt     = shot_cnt;
      toggle_pulse = 1'b0;
      shot_pulse   = 1'b0;
      bonus_pulse  = 1'b0;

      if (!bus.gameActive) begin
         nxt_state  = S_IDLE;
         frame_nxt  = 10'd0;
         toggle_nxt = 10'd0;
         shot_nxt   = 10'd0;
      end else begin
         case (cur_state)
            S_IDLE: begin
               nxt_state = S_WAIT;
               frame_nxt = 10'd0;
            end
            S_WAIT: begin
               if (bus.startOfFrame) begin
                  if (frame_inc == SPAWN_LIM) begin
                     nxt_state  = S_FLY;
                     frame_nxt  = 10'd0;
                     toggle_nxt = 10'd0;
                     shot_nxt   = 10'd0;
                  end else begin
                     frame_nxt = frame_inc;
                  end
               end
            end
            S_FLY: begin
               // A hit wins over everything the same frame pulse would do.
               if (bus.lrrrHit) begin
                  nxt_state   = S_EXPLODE;
                  frame_nxt   = 10'd0;
                  bonus_pulse = 1'b1;
               end else if (bus.startOfFrame) begin
                  if (toggle_inc == TOGGLE_LIM) begin
                     toggle_pulse = 1'b1;
                     toggle_nxt   = 10'd0;
                  end else begin
                     toggle_nxt = toggle_inc;
                  end
                  if (shot_inc == SHOT_LIM) begin
                     shot_pulse = 1'b1;
                     shot_nxt   = 10'd0;
                  end else begin
                     shot_nxt = shot_inc;
                  end
                  if (frame_inc == FLY_LIM) begin
                     nxt_state = S_WAIT;
                     frame_nxt = 10'd0;
                  end else begin
                     frame_nxt = frame_inc;
                  end
               end
            end
            S_EXPLODE: begin
               if (bus.startOfFrame) begin
                  if (frame_inc == EXPLODE_LIM) begin
                     nxt_state = S_WAIT;
                     frame_nxt = 10'd0;
                  end else begin
                     frame_nxt = frame_inc;
                  end
               end
            end
            default: nxt_state = S_IDLE;
         endcase
      end
   end

   // Level outputs are decoded from the next state so they move on the same
   // clk as the state register.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         cur_state       <= S_IDLE;
         frame_cnt       <= 10'd0;
         toggle_cnt      <= 10'd0;
         shot_cnt        <= 10'd0;
         bus.idleN       <= 1'b0;
         bus.lrrrVisible <= 1'b0;
         bus.explodeOn   <= 1'b0;
         bus.toggleY     <= 1'b0;
         bus.lrrrShoot   <= 1'b0;
         bus.hitBonus    <= 1'b0;
      end else begin
         cur_state       <= nxt_state;
         frame_cnt       <= frame_nxt;
         toggle_cnt      <= toggle_nxt;
         shot_cnt        <= shot_nxt;
         bus.idleN       <= (nxt_state == S_FLY) || (nxt_state == S_EXPLODE);
         bus.lrrrVisible <= (nxt_state == S_FLY);
         bus.explodeOn   <= (nxt_state == S_EXPLODE);
         bus.toggleY     <= toggle_pulse;
         bus.lrrrShoot   <= shot_pulse;
         bus.hitBonus    <= bonus_pulse;
      end
   end

   assign bus.state = cur_state;

endmodule

// File: tb/tb_lrrr_sequencer.sv
// tb/tb_lrrr_sequencer.sv - self-checking bench for lrrr_sequencer
module tb_lrrr_sequencer;

   logic clk = 1'b0;
   logic resetN;
   always #5 clk = ~clk;

   lrrr_sequencer_if dif ();

   lrrr_sequencer #(
      .SPAWN_DELAY   (3),
      .FLY_FRAMES    (10),
      .TOGGLE_PERIOD (4),
      .SHOT_PERIOD   (5),
      .EXPLODE_FRAMES(2)
   ) dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (dif)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit last_sof;

   // Reference model: state number, frames spent in current state, expected outputs.
   int m_st, m_fr;
   bit e_idle_n, e_tog, e_vis, e_exp, e_shot, e_bonus;

   function automatic logic [7:0] dut_vec();
      return {dif.state, dif.idleN, dif.toggleY, dif.lrrrVisible,
              dif.explodeOn, dif.lrrrShoot, dif.hitBonus};
   endfunction

   function automatic logic [7:0] exp_vec();
      return {2'(m_st), e_idle_n, e_tog, e_vis, e_exp, e_shot, e_bonus};
   endfunction

   function automatic void model_reset();
      m_st = 0; m_fr = 0;
      e_idle_n = 0; e_tog = 0; e_vis = 0; e_exp = 0; e_shot = 0; e_bonus = 0;
   endfunction

   function automatic void model_step(input bit ga, input bit sof, input bit hit);
      e_tog = 0; e_shot = 0; e_bonus = 0;
      if (!ga) begin
         m_st = 0; m_fr = 0;
      end else begin
         case (m_st)
            0: begin m_st = 1; m_fr = 0; end
            1: if (sof) begin
                  m_fr++;
                  if (m_fr == 3) begin m_st = 2; m_fr = 0; end
               end
            2: if (hit) begin
                  m_st = 3; m_fr = 0; e_bonus = 1;
               end else if (sof) begin
                  m_fr++;
                  e_tog  = (m_fr % 4 == 0);
                  e_shot = (m_fr % 5 == 0);
                  if (m_fr == 10) begin m_st = 1; m_fr = 0; end
               end
            default: if (sof) begin
                  m_fr++;
                  if (m_fr == 2) begin m_st = 1; m_fr = 0; end
               end
         endcase
      end
      e_idle_n = (m_st >= 2);
      e_vis    = (m_st == 2);
      e_exp    = (m_st == 3);
   endfunction

   task automatic tick(input bit ga, input bit hit);
      bit sof;
      sof = (cyc % 8 == 0);
      dif.gameActive   = ga;
      dif.lrrrHit      = hit;
      dif.startOfFrame = sof;
      last_sof = sof;
      model_step(ga, sof, hit);
      cyc++;
      @(posedge clk);
      #1;
      dif.lrrrHit      = 1'b0;
      dif.startOfFrame = 1'b0;
   endtask

   task automatic goto_state(input int target);
      int i;
      for (i = 0; i < 300 && m_st != target; i++) tick(1'b1, 1'b0);
      checks++;
      if (m_st != target) begin
         errors++;
         $display("FAIL goto_state: model stuck in %0d, required %0d", m_st, target);
      end
   endtask

   task automatic test_reset();
      int n;
      resetN = 1'b0;
      dif.gameActive = 1'b1; dif.lrrrHit = 1'b0; dif.startOfFrame = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (dut_vec() !== 8'h00) begin
         errors++; $display("FAIL reset_outputs: got %h required 00", dut_vec());
      end
      resetN = 1'b1;
      model_reset();
      cyc = 0;
      tick(1'b1, 1'b0);
      checks++;
      if (dif.state !== 2'd1 || dif.idleN !== 1'b0) begin
         errors++; $display("FAIL reset_to_wait: state %0d idleN %b required 1/0", dif.state, dif.idleN);
      end
      n = 0;
      for (int i = 0; i < 40; i++) begin
         tick(1'b1, 1'b0);
         if (last_sof) n++;
         checks++;
         if (n < 3) begin
            if (dif.state !== 2'd1 || dif.idleN !== 1'b0) begin
               errors++; $display("FAIL wait_hold: frame %0d state %0d idleN %b required 1/0", n, dif.state, dif.idleN);
            end
         end else begin
            if (dif.state !== 2'd2 || dif.idleN !== 1'b1) begin
               errors++; $display("FAIL wait_to_fly: state %0d idleN %b required 2/1", dif.state, dif.idleN);
            end
            break;
         end
      end
      checks++;
      if (n != 3) begin errors++; $display("FAIL wait_timeout: frames %0d required 3", n); end
   endtask

   task automatic test_fly_escape();
      logic [10:0] tm, sm;
      int n;
      bit wide, bonus_seen;
      tm = '0; sm = '0; n = 0; wide = 0; bonus_seen = 0;
      for (int i = 0; i < 200; i++) begin
         tick(1'b1, 1'b0);
         if (last_sof) n++;
         if ((dif.toggleY === 1'b1 || dif.lrrrShoot === 1'b1) && !last_sof) wide = 1;
         if (dif.toggleY === 1'b1 && n <= 10) tm[n] = 1'b1;
         if (dif.lrrrShoot === 1'b1 && n <= 10) sm[n] = 1'b1;
         if (dif.hitBonus === 1'b1) bonus_seen = 1;
         if (dif.state !== 2'd2) break;
      end
      checks++;
      if (tm !== 11'h110) begin errors++; $display("FAIL fly_toggle_frames: mask %h required 110", tm); end
      checks++;
      if (sm !== 11'h420) begin errors++; $display("FAIL fly_shot_frames: mask %h required 420", sm); end
      checks++;
      if (wide) begin errors++; $display("FAIL fly_pulse_width: pulse outside frame clk, required 1-clk pulses"); end
      checks++;
      if (n != 10 || dif.state !== 2'd1 || dif.idleN !== 1'b0 || bonus_seen) begin
         errors++;
         $display("FAIL fly_escape: frames %0d state %0d idleN %b bonus %b required 10/1/0/0",
                  n, dif.state, dif.idleN, bonus_seen);
      end
   endtask

   task automatic test_hit();
      int n;
      goto_state(2);
      n = 0;
      for (int i = 0; i < 100 && n < 6; i++) begin
         tick(1'b1, 1'b0);
         if (last_sof) n++;
      end
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      checks++;
      if (dut_vec() !== 8'b11_1_0_0_1_0_1) begin
         errors++; $display("FAIL hit_explode: got %b required 11100101", dut_vec());
      end
      tick(1'b1, 1'b0);
      checks++;
      if (dif.hitBonus !== 1'b0 || dif.state !== 2'd3) begin
         errors++; $display("FAIL hit_bonus_width: bonus %b state %0d required 0/3", dif.hitBonus, dif.state);
      end
      n = 0;
      for (int i = 0; i < 40 && n < 2; i++) begin
         tick(1'b1, 1'b0);
         if (last_sof) n++;
      end
      checks++;
      if (n != 2 || dif.state !== 2'd1 || dif.explodeOn !== 1'b0 || dif.idleN !== 1'b0) begin
         errors++;
         $display("FAIL explode_end: frames %0d state %0d explodeOn %b idleN %b required 2/1/0/0",
                  n, dif.state, dif.explodeOn, dif.idleN);
      end
   endtask

   task automatic test_hit_on_toggle();
      int n;
      goto_state(2);
      n = 0;
      for (int i = 0; i < 100 && n < 3; i++) begin
         tick(1'b1, 1'b0);
         if (last_sof) n++;
      end
      for (int i = 0; i < 8 && (cyc % 8) != 0; i++) tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      checks++;
      if (dif.state !== 2'd3 || dif.toggleY !== 1'b0 || dif.hitBonus !== 1'b1) begin
         errors++;
         $display("FAIL hit_on_toggle: state %0d toggleY %b bonus %b required 3/0/1",
                  dif.state, dif.toggleY, dif.hitBonus);
      end
      goto_state(1);
   endtask

   task automatic test_game_off();
      int n;
      goto_state(2);
      repeat (5) tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      checks++;
      if (dut_vec() !== 8'h00) begin errors++; $display("FAIL game_off: got %h required 00", dut_vec()); end
      tick(1'b0, 1'b1);
      checks++;
      if (dut_vec() !== 8'h00) begin errors++; $display("FAIL game_off_hit: got %h required 00", dut_vec()); end
      tick(1'b1, 1'b0);
      checks++;
      if (dif.state !== 2'd1) begin errors++; $display("FAIL game_on_wait: state %0d required 1", dif.state); end
      n = 0;
      for (int i = 0; i < 40; i++) begin
         tick(1'b1, 1'b0);
         if (last_sof) n++;
         if (dif.state !== 2'd1) break;
      end
      checks++;
      if (n != 3 || dif.state !== 2'd2) begin
         errors++; $display("FAIL game_on_full_wait: frames %0d state %0d required 3/2", n, dif.state);
      end
   endtask

   task automatic test_hit_ignored();
      tick(1'b0, 1'b1);
      checks++;
      if (dif.state !== 2'd0 || dif.hitBonus !== 1'b0) begin
         errors++; $display("FAIL ign_idle: state %0d bonus %b required 0/0", dif.state, dif.hitBonus);
      end
      tick(1'b1, 1'b1);
      checks++;
      if (dif.state !== 2'd1 || dif.hitBonus !== 1'b0) begin
         errors++; $display("FAIL ign_idle_exit: state %0d bonus %b required 1/0", dif.state, dif.hitBonus);
      end
      tick(1'b1, 1'b1);
      checks++;
      if (dif.state !== 2'd1 || dif.hitBonus !== 1'b0) begin
         errors++; $display("FAIL ign_wait: state %0d bonus %b required 1/0", dif.state, dif.hitBonus);
      end
      goto_state(2);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      checks++;
      if (dif.state !== 2'd3 || dif.hitBonus !== 1'b0) begin
         errors++; $display("FAIL ign_explode: state %0d bonus %b required 3/0", dif.state, dif.hitBonus);
      end
   endtask

   task automatic test_random();
      bit ga, hit;
      for (int i = 0; i < 3000; i++) begin
         ga  = ($urandom_range(0, 99) != 0);
         hit = ($urandom_range(0, 14) == 0);
         tick(ga, hit);
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL random cyc %0d: got %b required %b", cyc, dut_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      dif.gameActive = 1'b0; dif.lrrrHit = 1'b0; dif.startOfFrame = 1'b0;
      resetN = 1'b0;
      model_reset();
      test_reset();
      test_fly_escape();
      test_hit();
      test_hit_on_toggle();
      test_game_off();
      test_hit_ignored();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
